// File: rtl/tts_ctrl_pkg.sv
// Shared definitions for the NES/SNES controller emulator: button indices,
// frame lengths, FSM state encoding and line bit-order maps.
package tts_ctrl_pkg;

  localparam logic [3:0] BTN_B      = 4'd0;
  localparam logic [3:0] BTN_Y      = 4'd1;
  localparam logic [3:0] BTN_SELECT = 4'd2;
  localparam logic [3:0] BTN_START  = 4'd3;
  localparam logic [3:0] BTN_UP     = 4'd4;
  localparam logic [3:0] BTN_DOWN   = 4'd5;
  localparam logic [3:0] BTN_LEFT   = 4'd6;
  localparam logic [3:0] BTN_RIGHT  = 4'd7;
  localparam logic [3:0] BTN_A      = 4'd8;
  localparam logic [3:0] BTN_X      = 4'd9;
  localparam logic [3:0] BTN_L      = 4'd10;
  localparam logic [3:0] BTN_R      = 4'd11;

  localparam int NES_FRAME_BITS  = 8;
  localparam int SNES_FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic [3:0] NES_MAP [NES_FRAME_BITS] = '{
    BTN_A, BTN_B, BTN_SELECT, BTN_START, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT
  };

  localparam logic [3:0] SNES_MAP [12] = '{
    BTN_B, BTN_Y, BTN_SELECT, BTN_START, BTN_UP, BTN_DOWN,
    BTN_LEFT, BTN_RIGHT, BTN_A, BTN_X, BTN_L, BTN_R
  };

  // Line levels, bit 0 first on the wire; pressed buttons read as 0.
  function automatic logic [15:0] build_frame(input logic [11:0] btn,
                                               input logic        snes,
                                               input logic [3:0]  snes_id);
    logic [15:0] f;
    f = '1;
    if (snes) begin
      for (int i = 0; i < 12; i++) f[i] = ~btn[SNES_MAP[i]];
      for (int i = 0; i < 4; i++) f[12+i] = snes_id[i];
    end else begin
      for (int i = 0; i < NES_FRAME_BITS; i++) f[i] = ~btn[NES_MAP[i]];
    end
    return f;
  endfunction

endpackage

// File: rtl/ctrl_edge_sync.sv
// Multi-flop synchronizer for an asynchronous host line, with single-cycle
// rise/fall pulses derived from the synchronized level.
module ctrl_edge_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/nes_controller_emulator.sv
// NES/SNES gamepad responder with 4021-style shift-out of the button frame.
// Optional turbo on A/B is enabled by defining CTRL_EMU_TURBO_EN.
module nes_controller_emulator
  import tts_ctrl_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic       FILL_LEVEL  = 1'b0,
  parameter logic [3:0] SNES_ID     = 4'b1111
`ifdef CTRL_EMU_TURBO_EN
  , parameter int unsigned TURBO_DIV = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] buttons,
  input  logic        snes_mode,
  input  logic        host_latch,
  input  logic        host_clk,
  output logic        data_out,
  output logic        frame_done,
  output logic [4:0]  bit_index
`ifdef CTRL_EMU_TURBO_EN
  , input  logic [1:0] turbo_mask
`endif
);

  logic latch_level, latch_rise, latch_fall;
  logic clk_level, clk_rise, clk_fall;

  ctrl_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_latch_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (host_latch),
    .level    (latch_level),
    .rise     (latch_rise),
    .fall     (latch_fall)
  );

  ctrl_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (host_clk),
    .level    (clk_level),
    .rise     (clk_rise),
    .fall     (clk_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, latch_rise, clk_level, clk_fall};

  logic [11:0] eff_buttons;

`ifdef CTRL_EMU_TURBO_EN
  logic [2:0] turbo_cnt;
  logic       turbo_off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) turbo_cnt <= '0;
    else if (latch_fall) turbo_cnt <= turbo_cnt + 3'd1;
  end

  // Masked buttons read released during the odd TURBO_DIV-frame windows.
  assign turbo_off = ((32'(turbo_cnt) / TURBO_DIV) % 32'd2) != 32'd0;

  always_comb begin
    eff_buttons = buttons;
    if (turbo_off) begin
      eff_buttons[BTN_A] = buttons[BTN_A] & ~turbo_mask[0];
      eff_buttons[BTN_B] = buttons[BTN_B] & ~turbo_mask[1];
    end
  end
`else
  assign eff_buttons = buttons;
`endif

  state_t      state;
  logic [15:0] shift_q;
  logic        snes_q;
  logic        filled_q;
  logic [15:0] load_frame;
  logic [4:0]  frame_len;
  logic [4:0]  bit_next;

  assign load_frame = build_frame(eff_buttons, snes_mode, SNES_ID);
  assign frame_len  = snes_q ? 5'(SNES_FRAME_BITS) : 5'(NES_FRAME_BITS);
  assign bit_next   = bit_index + 5'd1;

  // A high latch overrides everything, which also makes latch win a race
  // against a host clock edge detected in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_q    <= '1;
      snes_q     <= 1'b0;
      filled_q   <= 1'b0;
      bit_index  <= '0;
      data_out   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (latch_level) begin
        state     <= LOAD;
        shift_q   <= load_frame;
        snes_q    <= snes_mode;
        bit_index <= '0;
        data_out  <= load_frame[0];
      end else begin
        case (state)
          IDLE: begin
            data_out <= filled_q ? FILL_LEVEL : 1'b1;
          end
          LOAD: begin
            state <= SHIFT;
          end
          SHIFT: begin
            if (clk_rise) begin
              shift_q   <= {FILL_LEVEL, shift_q[15:1]};
              bit_index <= bit_next;
              if (bit_next == frame_len) begin
                data_out   <= FILL_LEVEL;
                frame_done <= 1'b1;
                filled_q   <= 1'b1;
                state      <= IDLE;
              end else begin
                data_out <= shift_q[1];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
